// File: rtl/uart_tx_serial.sv
// Byte-wide UART transmitter: one 8N1 / 8E1 / 8O1 frame per accepted write.
// Each bit lasts 4 prescaler ticks of max(i_div,1) clocks each.
module uart_tx_serial #(
    parameter int unsigned DIV_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_l,
    input  logic             i_en_h,
    input  logic [DIV_W-1:0] i_div,
    input  logic [7:0]       i_tx_data,
    input  logic             i_we_h,
    input  logic             i_parity_en_h,
    input  logic             i_parity_type_el_oh,
    output logic             o_tx,
    output logic             o_busy_h
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t           state;
    logic [7:0]       data_q;
    logic             par_en_q;
    logic             par_bit_q;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] pre_cnt;
    logic [1:0]       tick_cnt;
    logic [2:0]       bit_idx;

    logic             pre_last_c;
    logic             bit_end_c;

    // Last clock of a tick, and last clock of the 4-tick bit.
    assign pre_last_c = (pre_cnt == div_q - DIV_W'(1));
    assign bit_end_c  = pre_last_c && (tick_cnt == 2'd3);

    always_ff @(posedge i_clk or negedge i_rst_l) begin
        if (!i_rst_l) begin
            state     <= ST_IDLE;
            data_q    <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            div_q     <= DIV_W'(1);
            pre_cnt   <= '0;
            tick_cnt  <= '0;
            bit_idx   <= '0;
            o_tx      <= 1'b1;
            o_busy_h  <= 1'b0;
        end else if (!i_en_h) begin
            state    <= ST_IDLE;
            pre_cnt  <= '0;
            tick_cnt <= '0;
            bit_idx  <= '0;
            o_tx     <= 1'b1;
            o_busy_h <= 1'b0;
        end else if (state == ST_IDLE) begin
            // Frame parameters are frozen here so later input changes cannot disturb the frame.
            if (i_we_h) begin
                state     <= ST_START;
                data_q    <= i_tx_data;
                par_en_q  <= i_parity_en_h;
                par_bit_q <= (^i_tx_data) ^ i_parity_type_el_oh;
                div_q     <= (i_div == '0) ? DIV_W'(1) : i_div;
                pre_cnt   <= '0;
                tick_cnt  <= '0;
                bit_idx   <= '0;
                o_tx      <= 1'b0;
                o_busy_h  <= 1'b1;
            end
        end else begin
            if (pre_last_c) begin
                pre_cnt  <= '0;
                tick_cnt <= tick_cnt + 2'd1;
            end else begin
                pre_cnt <= pre_cnt + DIV_W'(1);
            end

            if (bit_end_c) begin
                case (state)
                    ST_START: begin
                        state   <= ST_DATA;
                        bit_idx <= '0;
                        o_tx    <= data_q[0];
                    end
                    ST_DATA: begin
                        if (bit_idx == 3'd7) begin
                            bit_idx <= '0;
                            if (par_en_q) begin
                                state <= ST_PARITY;
                                o_tx  <= par_bit_q;
                            end else begin
                                state <= ST_STOP;
                                o_tx  <= 1'b1;
                            end
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            o_tx    <= data_q[3'(bit_idx + 3'd1)];
                        end
                    end
                    ST_PARITY: begin
                        state <= ST_STOP;
                        o_tx  <= 1'b1;
                    end
                    ST_STOP: begin
                        state    <= ST_IDLE;
                        o_tx     <= 1'b1;
                        o_busy_h <= 1'b0;
                    end
                    default: begin
                        state    <= ST_IDLE;
                        o_tx     <= 1'b1;
                        o_busy_h <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_serial.sv
// Randomised self-checking bench for uart_tx_serial against a per-cycle frame model
// (frame = array of bit values, expected line = bit[offset / bit_length]).
module tb_uart_tx_serial;

    localparam int unsigned DIV_W = 16;

    logic             i_clk = 1'b0;
    logic             i_rst_l = 1'b0;
    logic             i_en_h = 1'b0;
    logic [DIV_W-1:0] i_div = '0;
    logic [7:0]       i_tx_data = '0;
    logic             i_we_h = 1'b0;
    logic             i_parity_en_h = 1'b0;
    logic             i_parity_type_el_oh = 1'b0;
    logic             o_tx;
    logic             o_busy_h;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    uart_tx_serial #(.DIV_W(DIV_W)) dut (
        .i_clk               (i_clk),
        .i_rst_l             (i_rst_l),
        .i_en_h              (i_en_h),
        .i_div               (i_div),
        .i_tx_data           (i_tx_data),
        .i_we_h              (i_we_h),
        .i_parity_en_h       (i_parity_en_h),
        .i_parity_type_el_oh (i_parity_type_el_oh),
        .o_tx                (o_tx),
        .o_busy_h            (o_busy_h)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic int eff_div(input logic [DIV_W-1:0] d);
        return (d == '0) ? 1 : int'(d);
    endfunction

    // Parity bit from a ones count: even parity makes the total count even.
    function automatic logic ref_parity(input logic [7:0] d, input logic odd);
        int n = 0;
        for (int i = 0; i < 8; i++) n += int'(d[i]);
        return logic'(n % 2 == 1) ^ odd;
    endfunction

    // Reference model: active flag, cycle offset into the frame, frame bits, bit length.
    logic m_active;
    int   m_off;
    int   m_len;
    int   m_d;
    logic m_bits [0:10];

    always @(posedge i_clk or negedge i_rst_l) begin
        if (!i_rst_l) begin
            m_active <= 1'b0;
            m_off    <= 0;
            m_d      <= 1;
        end else if (!i_en_h) begin
            m_active <= 1'b0;
        end else if (m_active) begin
            if (m_off + 1 >= m_len) m_active <= 1'b0;
            else m_off <= m_off + 1;
        end else if (i_we_h) begin
            m_active <= 1'b1;
            m_off    <= 0;
            m_d      <= eff_div(i_div);
            m_len    <= (i_parity_en_h ? 44 : 40) * eff_div(i_div);
            m_bits[0] <= 1'b0;
            for (int i = 0; i < 8; i++) m_bits[i+1] <= i_tx_data[i];
            m_bits[9]  <= i_parity_en_h ? ref_parity(i_tx_data, i_parity_type_el_oh) : 1'b1;
            m_bits[10] <= 1'b1;
        end
    end

    always @(negedge i_clk) begin
        if (chk_en) begin
            check("tx", 32'(o_tx), 32'(m_active ? m_bits[m_off / (4 * m_d)] : 1'b1));
            check("busy", 32'(o_busy_h), 32'(m_active));
        end
    end

    // Present one write strobe for a single cycle (called on a falling edge).
    task automatic send(input logic [7:0] d, input int dv, input logic pe, input logic po);
        i_tx_data           = d;
        i_div               = DIV_W'(dv);
        i_parity_en_h       = pe;
        i_parity_type_el_oh = po;
        i_we_h              = 1'b1;
        @(negedge i_clk);
        i_we_h = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (o_busy_h !== 1'b0 && n < 2000) begin
            @(negedge i_clk);
            n++;
        end
        if (n >= 2000) check("idle_timeout", 32'(o_busy_h), 32'd0);
    endtask

    // Decode a frame by sampling once per bit; call right after send().
    task automatic rx(input int d, input logic pe, output logic [7:0] b, output logic p);
        int n = 0;
        b = '0;
        p = 1'b0;
        while (o_tx !== 1'b0 && n < 100) begin
            @(negedge i_clk);
            n++;
        end
        if (n >= 100) check("start_timeout", 32'(o_tx), 32'd0);
        for (int i = 0; i < 8; i++) begin
            repeat (4 * d) @(negedge i_clk);
            b[i] = o_tx;
        end
        if (pe) begin
            repeat (4 * d) @(negedge i_clk);
            p = o_tx;
        end
        repeat (4 * d) @(negedge i_clk);
        check("stop_bit", 32'(o_tx), 32'd1);
    endtask

    initial begin
        logic [7:0] b;
        logic       p;
        int         cnt;
        int         d;

        repeat (3) @(negedge i_clk);
        check("rst_tx", 32'(o_tx), 32'd1);
        check("rst_busy", 32'(o_busy_h), 32'd0);
        chk_en  = 1'b1;
        i_rst_l = 1'b1;
        i_en_h  = 1'b1;
        @(negedge i_clk);

        // Basic 8N1: busy length measured directly.
        send(8'h55, 1, 1'b0, 1'b0);
        cnt = 0;
        while (o_busy_h === 1'b1 && cnt < 200) begin
            cnt++;
            @(negedge i_clk);
        end
        check("busy_len_55", 32'(cnt), 32'd40);
        @(negedge i_clk);

        // Parity variants.
        send(8'h30, 3, 1'b1, 1'b0);
        rx(3, 1'b1, b, p);
        check("even30_byte", 32'(b), 32'h30);
        check("even30_par", 32'(p), 32'd0);
        wait_idle();
        @(negedge i_clk);
        send(8'h30, 3, 1'b1, 1'b1);
        rx(3, 1'b1, b, p);
        check("odd30_par", 32'(p), 32'd1);
        wait_idle();
        @(negedge i_clk);
        send(8'h31, 3, 1'b1, 1'b0);
        rx(3, 1'b1, b, p);
        check("even31_par", 32'(p), 32'd1);
        wait_idle();
        @(negedge i_clk);

        // Write while busy is dropped.
        send(8'h41, 2, 1'b0, 1'b0);
        repeat (4) @(negedge i_clk);
        send(8'hFF, 2, 1'b0, 1'b0);
        wait_idle();
        repeat (50) @(negedge i_clk);
        check("no_second_frame", 32'(o_busy_h), 32'd0);

        // Printer-style back-to-back "0x".
        send(8'h30, 1, 1'b0, 1'b0);
        wait_idle();
        send(8'h78, 1, 1'b0, 1'b0);
        check("poll_busy", 32'(o_busy_h), 32'd1);
        wait_idle();
        @(negedge i_clk);

        // Asynchronous reset during data bit 3.
        send(8'h96, 2, 1'b0, 1'b0);
        repeat (4 * 2 * 4 + 3) @(negedge i_clk);
        #2 i_rst_l = 1'b0;
        #1;
        check("arst_tx", 32'(o_tx), 32'd1);
        check("arst_busy", 32'(o_busy_h), 32'd0);
        @(negedge i_clk);
        i_rst_l = 1'b1;
        @(negedge i_clk);
        send(8'h3C, 2, 1'b0, 1'b0);
        rx(2, 1'b0, b, p);
        check("post_rst_byte", 32'(b), 32'h3C);
        wait_idle();
        @(negedge i_clk);

        // Disable during the stop bit, then writes while disabled.
        send(8'h12, 1, 1'b0, 1'b0);
        repeat (37) @(negedge i_clk);
        i_en_h = 1'b0;
        @(negedge i_clk);
        check("dis_busy", 32'(o_busy_h), 32'd0);
        check("dis_tx", 32'(o_tx), 32'd1);
        send(8'h00, 1, 1'b0, 1'b0);
        check("dis_write", 32'(o_busy_h), 32'd0);
        i_en_h = 1'b1;
        @(negedge i_clk);

        // Divider zero behaves as divider one.
        send(8'hA5, 0, 1'b0, 1'b0);
        rx(1, 1'b0, b, p);
        check("div0_byte", 32'(b), 32'hA5);
        wait_idle();
        @(negedge i_clk);

        // Random frames with input scrambling, stray writes, aborts and tight gaps.
        for (int it = 0; it < 40; it++) begin
            d = int'($urandom_range(0, 4));
            send(8'($urandom), d, 1'($urandom), 1'($urandom));
            for (int k = 0; k < int'($urandom_range(1, 12)); k++) begin
                i_div               = DIV_W'($urandom_range(0, 6));
                i_tx_data           = 8'($urandom);
                i_parity_en_h       = 1'($urandom);
                i_parity_type_el_oh = 1'($urandom);
                i_we_h              = ($urandom_range(0, 3) == 0);
                @(negedge i_clk);
                i_we_h = 1'b0;
            end
            if ($urandom_range(0, 7) == 0) begin
                repeat ($urandom_range(0, 60)) @(negedge i_clk);
                i_en_h = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge i_clk);
                i_en_h = 1'b1;
            end
            wait_idle();
            repeat ($urandom_range(0, 2)) @(negedge i_clk);
        end
        wait_idle();
        repeat (4) @(negedge i_clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
